// File: rtl/man_sched_pkg.sv
// Shared types and constants for the Manchester receive scheduler.
package man_sched_pkg;

    // Scheduler states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SWITCH = 3'd1,
        ST_LISTEN = 3'd2,
        ST_RECV   = 3'd3,
        ST_HOLD   = 3'd4
    } sched_state_e;

    // Cycles the sampler is held in reset while the line mux changes.
    localparam int C_SWITCH_CYC = 2;

    // Width of the saturating frame-timeout counter.
    localparam int C_ERR_W = 8;

    // Default parameter values.
    localparam int C_CH_NUM_DEF   = 4;
    localparam int C_IDLE_TO_DEF  = 64;
    localparam int C_FRAME_TO_DEF = 128;

endpackage

// File: rtl/man_rr_pick.sv
// Round-robin picker: nearest enabled channel strictly after the current one,
// wrapping around; returns the current channel if it is the only one enabled.
module man_rr_pick #(
    parameter int P_CH_NUM = 4,
    parameter int P_CH_W   = 2
) (
    input  logic [P_CH_NUM-1:0] i_enable,
    input  logic [P_CH_W-1:0]   i_cur,
    output logic [P_CH_W-1:0]   o_next,
    output logic                o_any_en
);

    function automatic logic [P_CH_W-1:0] f_wrap(input int v);
        return P_CH_W'(v % P_CH_NUM);
    endfunction

    // Scan from the furthest candidate to the nearest so the nearest enabled one wins.
    always_comb begin
        o_next   = i_cur;
        o_any_en = |i_enable;
        for (int k = P_CH_NUM; k >= 1; k--) begin
            if (i_enable[f_wrap(int'(i_cur) + k)]) begin
                o_next = f_wrap(int'(i_cur) + k);
            end
        end
    end

endmodule

// File: rtl/man_rx_sched.sv
// Time-shares one Manchester sampler among several CCDL receive lines:
// selects a line, waits for a frame header, captures the sampled word with
// its channel tag and hands it downstream.
//
// Output handshake: O_word_valid rises with O_word_data/O_word_ch stable and
// they stay unchanged until a cycle where O_word_valid and I_word_ready are
// both 1; that cycle is the single transfer, and O_word_valid is 0 after it.
module man_rx_sched
    import man_sched_pkg::*;
#(
    parameter int P_CH_NUM   = C_CH_NUM_DEF,
    parameter int P_CH_W     = 2,
    parameter int P_IDLE_TO  = C_IDLE_TO_DEF,
    parameter int P_FRAME_TO = C_FRAME_TO_DEF
) (
    input  logic                I_sys_clk,
    input  logic                I_rst,
    input  logic [P_CH_NUM-1:0] I_ccdl_in,
    input  logic [P_CH_NUM-1:0] I_ch_enable,
    output logic                O_ccdl_sel,
    output logic                O_smp_rst_n,
    input  logic [31:0]         I_sample_data,
    input  logic                I_sample_valid,
    output logic [31:0]         O_word_data,
    output logic [P_CH_W-1:0]   O_word_ch,
    output logic                O_word_valid,
    input  logic                I_word_ready,
    output logic [P_CH_W-1:0]   O_cur_ch,
    output logic                O_busy,
    output logic [C_ERR_W-1:0]  O_err_cnt
);

    localparam int C_IDLE_W = $clog2(P_IDLE_TO);
    localparam int C_FRM_W  = $clog2(P_FRAME_TO);
    localparam int C_SW_W   = (C_SWITCH_CYC > 1) ? $clog2(C_SWITCH_CYC) : 1;

    sched_state_e          r_state;
    sched_state_e          w_state_nxt;
    logic [P_CH_W-1:0]     r_cur_ch;
    logic [P_CH_W-1:0]     w_ch_nxt;
    logic [P_CH_W-1:0]     w_pick;
    logic                  w_any_en;
    logic                  w_cur_en;
    logic                  w_rise;
    logic                  w_idle_to;
    logic                  w_frame_to;
    logic                  w_sw_done;
    logic                  w_go_next;
    logic                  w_capture;
    logic                  w_err_inc;
    logic                  w_line_on;
    logic [C_IDLE_W-1:0]   r_idle_cnt;
    logic [C_FRM_W-1:0]    r_frame_cnt;
    logic [C_SW_W-1:0]     r_sw_cnt;
    logic                  r_ccdl_sel;
    logic                  r_sel_prev;
    logic [31:0]           r_word_data;
    logic [P_CH_W-1:0]     r_word_ch;
    logic [C_ERR_W-1:0]    r_err_cnt;

    man_rr_pick #(
        .P_CH_NUM (P_CH_NUM),
        .P_CH_W   (P_CH_W)
    ) u_pick (
        .i_enable (I_ch_enable),
        .i_cur    (r_cur_ch),
        .o_next   (w_pick),
        .o_any_en (w_any_en)
    );

    assign w_cur_en   = I_ch_enable[r_cur_ch];
    assign w_rise     = r_ccdl_sel & ~r_sel_prev;
    assign w_idle_to  = (r_idle_cnt == C_IDLE_W'(P_IDLE_TO - 1));
    assign w_frame_to = (r_frame_cnt == C_FRM_W'(P_FRAME_TO - 1));
    assign w_sw_done  = (r_sw_cnt == C_SW_W'(C_SWITCH_CYC - 1));
    assign w_line_on  = (w_state_nxt == ST_LISTEN) || (w_state_nxt == ST_RECV) ||
                        (w_state_nxt == ST_HOLD);

    // Next-state and channel selection; an abort (enable dropped) beats everything in LISTEN/RECV.
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_cur_ch;
        w_go_next   = 1'b0;
        w_capture   = 1'b0;
        w_err_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_go_next = w_any_en;
            end
            ST_SWITCH: begin
                if (w_sw_done) begin
                    w_state_nxt = ST_LISTEN;
                end
            end
            ST_LISTEN: begin
                if (!w_cur_en) begin
                    w_go_next = 1'b1;
                end else if (w_rise) begin
                    w_state_nxt = ST_RECV;
                end else if (w_idle_to) begin
                    w_go_next = 1'b1;
                end
            end
            ST_RECV: begin
                if (!w_cur_en) begin
                    w_go_next = 1'b1;
                end else if (I_sample_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else if (w_frame_to) begin
                    w_err_inc = 1'b1;
                    w_go_next = 1'b1;
                end
            end
            ST_HOLD: begin
                w_go_next = I_word_ready;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_go_next) begin
            if (w_any_en) begin
                w_state_nxt = ST_SWITCH;
                w_ch_nxt    = w_pick;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // State and owned-channel registers.
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            r_state  <= ST_IDLE;
            r_cur_ch <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cur_ch <= w_ch_nxt;
        end
    end

    // Switch, idle and frame counters; each restarts from 0 on entry to its state.
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            r_sw_cnt    <= '0;
            r_idle_cnt  <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_sw_cnt    <= (r_state == ST_SWITCH) ? r_sw_cnt + 1'b1 : '0;
            r_idle_cnt  <= (r_state == ST_LISTEN) ? r_idle_cnt + 1'b1 : '0;
            r_frame_cnt <= (r_state == ST_RECV) ? r_frame_cnt + 1'b1 : '0;
        end
    end

    // Registered line mux plus header edge history; history reads "high" outside
    // LISTEN so a line already high on arrival is not taken as a header.
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            r_ccdl_sel <= 1'b0;
            r_sel_prev <= 1'b1;
        end else begin
            r_ccdl_sel <= w_line_on ? I_ccdl_in[r_cur_ch] : 1'b0;
            r_sel_prev <= (r_state == ST_LISTEN) ? r_ccdl_sel : 1'b1;
        end
    end

    // Output word register, loaded once per captured frame.
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            r_word_data <= '0;
            r_word_ch   <= '0;
        end else if (w_capture) begin
            r_word_data <= I_sample_data;
            r_word_ch   <= r_cur_ch;
        end
    end

    // Saturating frame-timeout counter.
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            r_err_cnt <= '0;
        end else if (w_err_inc && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign O_ccdl_sel   = r_ccdl_sel;
    assign O_smp_rst_n  = (r_state == ST_LISTEN) || (r_state == ST_RECV) || (r_state == ST_HOLD);
    assign O_word_valid = (r_state == ST_HOLD);
    assign O_busy       = (r_state == ST_RECV) || (r_state == ST_HOLD);
    assign O_word_data  = r_word_data;
    assign O_word_ch    = r_word_ch;
    assign O_cur_ch     = r_cur_ch;
    assign O_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_man_rx_sched.sv
// Self-checking bench for man_rx_sched: visit table, corner sequences and
// randomized visits predicted by a round-robin/timing reference model.
module tb_man_rx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ccdl;
  logic [3:0]  en;
  logic        ccdl_sel;
  logic        smp_rst_n;
  logic [31:0] sdata;
  logic        svalid;
  logic [31:0] wdata;
  logic [1:0]  wch;
  logic        wvalid;
  logic        wready;
  logic [1:0]  cur_ch;
  logic        busy;
  logic [7:0]  err_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [33:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic [3:0]  mask;
    int          kind;
    logic [31:0] data;
    int          rise;
    int          vo;
    int          rdy;
    int          exp_ch;
    int          exp_err;
  } vis_t;

  vis_t tbl[9];

  man_rx_sched dut (
    .I_sys_clk      (clk),
    .I_rst          (rst),
    .I_ccdl_in      (ccdl),
    .I_ch_enable    (en),
    .O_ccdl_sel     (ccdl_sel),
    .O_smp_rst_n    (smp_rst_n),
    .I_sample_data  (sdata),
    .I_sample_valid (svalid),
    .O_word_data    (wdata),
    .O_word_ch      (wch),
    .O_word_valid   (wvalid),
    .I_word_ready   (wready),
    .O_cur_ch       (cur_ch),
    .O_busy         (busy),
    .O_err_cnt      (err_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // nearest enabled channel strictly after cur, wrapping (cur itself last)
  function automatic int model_next(input int cur, input logic [3:0] m);
    for (int k = 1; k <= 4; k++) begin
      if (m[(cur + k) % 4]) return (cur + k) % 4;
    end
    return cur;
  endfunction

  task automatic do_reset(input logic [3:0] m);
    rst = 1'b1; en = m; ccdl = '0; svalid = 1'b0; sdata = '0; wready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One channel visit, entered in the first SWITCH cycle, left in the next one.
  // kind 0: silent line, 1: frame delivered, 2: header then stalled frame.
  task automatic run_visit(input int kind, input logic [31:0] data, input int rise,
                           input int vo, input int rdy, input int exp_ch, input int exp_err);
    logic [33:0] w;
    chk("sw_cur_ch", cur_ch, exp_ch);
    chk("sw_smp_rst_n", smp_rst_n, 0);
    chk("sw_ccdl_sel", ccdl_sel, 0);
    tick();
    chk("sw2_smp_rst_n", smp_rst_n, 0);
    tick();
    chk("listen_smp_rst_n", smp_rst_n, 1);
    if (kind == 0) begin
      svalid = 1'b1; sdata = data;
      tick();
      svalid = 1'b0;
      repeat (62) tick();
      chk("listen_last", {busy, smp_rst_n, wvalid}, 3'b010);
      tick();
    end else begin
      repeat (rise - 1) tick();
      ccdl[exp_ch] = 1'b1;
      tick();
      chk("hdr_latency", busy, 0);
      tick();
      chk("recv_entry", busy, 1);
      ccdl = '0;
      if (kind == 1) begin
        repeat (vo) tick();
        svalid = 1'b1; sdata = data;
        tick();
        svalid = 1'b0; sdata = $urandom();
        exp_q.push_back({2'(exp_ch), data});
        for (int i = 0; i <= rdy; i++) begin
          chk("hold_valid", wvalid, 1);
          chk("hold_data", wdata, exp_q[0][31:0]);
          chk("hold_ch", wch, exp_q[0][33:32]);
          chk("hold_cur", cur_ch, exp_ch);
          chk("hold_smp_rst_n", smp_rst_n, 1);
          if (i == rdy) wready = 1'b1;
          tick();
        end
        wready = 1'b0;
        w = exp_q.pop_front();
        chk("post_xfer_valid", wvalid, 0);
      end else begin
        repeat (127) tick();
        chk("pre_timeout_busy", busy, 1);
        tick();
      end
    end
    chk("visit_err", err_cnt, exp_err);
    chk("visit_end_sw", smp_rst_n, 0);
  endtask

  initial begin
    logic [3:0] m;
    int mch;
    int merr;
    int kind;
    int vo;

    tbl[0] = '{1'b1, 4'hF, 0, 32'h0,         0,  0,   0, 1, 0};
    tbl[1] = '{1'b0, 4'hF, 1, 32'h5A5A_A5A5, 5,  60,  50, 2, 0};
    tbl[2] = '{1'b0, 4'hF, 2, 32'h0,         3,  0,   0, 3, 1};
    tbl[3] = '{1'b0, 4'hF, 1, 32'hDEAD_BEEF, 1,  127, 0, 0, 1};
    tbl[4] = '{1'b0, 4'hF, 0, 32'h1111_2222, 0,  0,   0, 1, 1};
    tbl[5] = '{1'b1, 4'hA, 0, 32'h0,         0,  0,   0, 1, 0};
    tbl[6] = '{1'b0, 4'hA, 1, 32'h1234_5678, 20, 10,  2, 3, 0};
    tbl[7] = '{1'b0, 4'hA, 0, 32'h0,         0,  0,   0, 1, 0};
    tbl[8] = '{1'b0, 4'hA, 2, 32'h0,         40, 0,   0, 3, 1};

    // reset values, all channels disabled
    do_reset(4'h0);
    chk("rst_cur_ch", cur_ch, 0);
    chk("rst_ccdl_sel", ccdl_sel, 0);
    chk("rst_smp_rst_n", smp_rst_n, 0);
    chk("rst_word_valid", wvalid, 0);
    chk("rst_word_data", wdata, 0);
    chk("rst_word_ch", wch, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_busy", busy, 0);
    repeat (3) tick();
    chk("idle_none_en", {smp_rst_n, busy, ccdl_sel}, 3'b000);

    // visit table
    for (int r = 0; r < 9; r++) begin
      if (tbl[r].rst) begin
        do_reset(tbl[r].mask);
        tick();
      end
      en = tbl[r].mask;
      run_visit(tbl[r].kind, tbl[r].data, tbl[r].rise, tbl[r].vo, tbl[r].rdy,
                tbl[r].exp_ch, tbl[r].exp_err);
    end

    // all enables dropped: LISTEN aborts into IDLE, channel and errors kept
    en = 4'h0;
    tick();
    tick();
    chk("drop_all_listen", smp_rst_n, 1);
    tick();
    chk("drop_all_idle", {smp_rst_n, busy}, 2'b00);
    chk("drop_all_cur", cur_ch, 1);
    chk("drop_all_err", err_cnt, 1);
    repeat (5) tick();
    chk("idle_stays", {smp_rst_n, ccdl_sel}, 2'b00);

    // line already high on arrival: no header until it falls and rises
    do_reset(4'hF);
    ccdl[1] = 1'b1;
    tick();
    chk("fe_cur", cur_ch, 1);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("fe_no_recv", busy, 0);
      tick();
    end
    ccdl[1] = 1'b0;
    tick();
    tick();
    ccdl[1] = 1'b1;
    tick();
    chk("fe_rise_latency", busy, 0);
    tick();
    chk("fe_recv", busy, 1);
    ccdl = '0;

    // enable dropped mid-frame: immediate switch, no error counted
    repeat (5) tick();
    en = 4'b1101;
    tick();
    chk("abort_sw", {smp_rst_n, busy}, 2'b00);
    chk("abort_cur", cur_ch, 2);
    chk("abort_err", err_cnt, 0);
    en = 4'hF;

    // reset while a word is held
    tick();
    tick();
    ccdl[2] = 1'b1;
    tick();
    tick();
    ccdl = '0;
    svalid = 1'b1; sdata = 32'hCAFE_F00D;
    tick();
    svalid = 1'b0;
    chk("rh_valid", wvalid, 1);
    chk("rh_data", wdata, 32'hCAFE_F00D);
    chk("rh_ch", wch, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rh_cur", cur_ch, 0);
    chk("rh_sel", ccdl_sel, 0);
    chk("rh_smp_rst_n", smp_rst_n, 0);
    chk("rh_wvalid", wvalid, 0);
    chk("rh_wdata", wdata, 0);
    chk("rh_wch", wch, 0);
    chk("rh_busy", busy, 0);

    // randomized visits against the round-robin / timing model
    for (int s = 0; s < 2; s++) begin
      m = 4'($urandom_range(1, 15));
      do_reset(m);
      tick();
      mch = model_next(0, m);
      merr = 0;
      for (int v = 0; v < 20; v++) begin
        kind = $urandom_range(0, 2);
        vo = ($urandom_range(0, 7) == 0) ? 127 : $urandom_range(0, 127);
        if (kind == 2) merr = (merr < 255) ? merr + 1 : 255;
        run_visit(kind, $urandom(), $urandom_range(1, 40), vo, $urandom_range(0, 5), mch, merr);
        mch = model_next(mch, m);
      end
    end

    // repeated frame timeouts saturate the error counter
    do_reset(4'hF);
    tick();
    mch = model_next(0, 4'hF);
    merr = 0;
    for (int v = 0; v < 260; v++) begin
      merr = (merr < 255) ? merr + 1 : 255;
      run_visit(2, 32'h0, 1, 0, 0, mch, merr);
      mch = model_next(mch, 4'hF);
    end
    chk("err_saturated", err_cnt, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
